// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared types and constants for the push-button debounce block.
//            Holds the per-channel debounce state encoding.
// Contents : BTN_STATE_W - width of the channel state register
//            btn_state_t - IDLE / PRESS_WAIT / HELD / RELEASE_WAIT
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

   localparam int BTN_STATE_W = 2;

   typedef enum logic [BTN_STATE_W-1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_channel
// Purpose  : One button channel. A two-flop synchroniser feeds a four-state
//            debounce FSM, which produces a clean level and one-cycle press
//            and release pulses. All outputs are registered.
// Ports    : clk         - system clock, rising edge
//            reset       - synchronous, active-high
//            i_btn_raw   - raw asynchronous button, 1 = pressed
//            o_level     - debounced level
//            o_pulse     - one-cycle pulse on accepted press (and repeats)
//            o_release   - one-cycle pulse on accepted release
// Options  : BTN_AUTO_REPEAT_EN - when defined, a held button issues further
//            o_pulse strobes after HOLD_CYCLES, then every REPEAT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int HOLD_CYCLES     = 500,
   parameter int REPEAT_CYCLES   = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn_raw,
   output logic o_level,
   output logic o_pulse,
   output logic o_release
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   // A single required sample means the WAIT states are bypassed entirely.
   localparam bit c_direct = (DEBOUNCE_CYCLES == 1);

   generate
      if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
         $error("btn_debounce_channel: cycle parameters must be >= 1");
      end
   endgenerate

`ifdef BTN_AUTO_REPEAT_EN
   localparam int REP_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] c_rep_first = REP_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0] c_rep_next  = REP_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0] c_rep_base  = REP_W'(HOLD_CYCLES);
   logic [REP_W-1:0] r_rep;
`endif

   logic             r_s1;
   logic             r_s2;
   btn_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_pulse;
   logic             r_release;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_pulse   <= 1'b0;
         r_release <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         r_rep     <= '0;
`endif
      end else begin
         r_s1      <= i_btn_raw;
         r_s2      <= r_s1;
         r_pulse   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef BTN_AUTO_REPEAT_EN
               r_rep <= '0;
`endif
               if (r_s2) begin
                  if (c_direct) begin
                     r_state <= HELD;
                     r_level <= 1'b1;
                     r_pulse <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= PRESS_WAIT;
                     r_cnt   <= c_cnt_one;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!r_s2) begin
                  // Glitch: silently back to IDLE.
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == c_cnt_max) begin
                  r_state <= HELD;
                  r_level <= 1'b1;
                  r_pulse <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
            HELD: begin
               if (!r_s2) begin
                  if (c_direct) begin
                     r_state   <= IDLE;
                     r_level   <= 1'b0;
                     r_release <= 1'b1;
                     r_cnt     <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                     r_rep     <= '0;
`endif
                  end else begin
                     r_state <= RELEASE_WAIT;
                     r_cnt   <= c_cnt_one;
                  end
               end
`ifdef BTN_AUTO_REPEAT_EN
               else begin
                  // First strobe after HOLD_CYCLES, then the counter folds
                  // back to HOLD_CYCLES so it strobes every REPEAT_CYCLES.
                  if (r_rep == c_rep_first || r_rep == c_rep_next) begin
                     r_pulse <= 1'b1;
                  end
                  if (r_rep == c_rep_next) begin
                     r_rep <= c_rep_base;
                  end else begin
                     r_rep <= r_rep + 1'b1;
                  end
               end
`endif
            end
            RELEASE_WAIT: begin
               if (r_s2) begin
                  // Release bounce: stay pressed; repeat timing is kept.
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == c_cnt_max) begin
                  r_state   <= IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
                  r_cnt     <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                  r_rep     <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_pulse   = r_pulse;
   assign o_release = r_release;

endmodule : btn_debounce_channel
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_pulse
// Purpose  : N_BTN independent push-button conditioners. Each raw input is
//            synchronised and debounced into a clean level plus one-cycle
//            press/release pulses, all updated on the rising clk edge so
//            they are stable for a downstream falling-edge stage.
// Ports    : clk           - system clock, rising edge
//            reset         - synchronous, active-high
//            i_btn_raw     - [N_BTN] raw asynchronous buttons, 1 = pressed
//            o_btn_level   - [N_BTN] debounced levels
//            o_btn_pulse   - [N_BTN] press pulses (plus auto-repeat)
//            o_btn_release - [N_BTN] release pulses
// Options  : BTN_AUTO_REPEAT_EN - enables hold-to-repeat press pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
   import btn_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int HOLD_CYCLES     = 500,
   parameter int REPEAT_CYCLES   = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] i_btn_raw,
   output logic [N_BTN-1:0] o_btn_level,
   output logic [N_BTN-1:0] o_btn_pulse,
   output logic [N_BTN-1:0] o_btn_release
);

   generate
      if (N_BTN < 1 || N_BTN > 16) begin : g_param_check
         $error("btn_debounce_pulse: N_BTN must be 1..16");
      end

      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
         btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
         ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .i_btn_raw (i_btn_raw[gi]),
            .o_level   (o_btn_level[gi]),
            .o_pulse   (o_btn_pulse[gi]),
            .o_release (o_btn_release[gi])
         );
      end
   endgenerate

endmodule : btn_debounce_pulse
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_pulse
// Purpose  : Directed self-checking bench for btn_debounce_pulse with
//            N_BTN=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
//            Observed vector is {level[1:0], pulse[1:0], release[1:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;

   localparam int N_BTN = 2;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit c_rep_en = 1'b1;
`else
   localparam bit c_rep_en = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic [N_BTN-1:0] i_btn_raw;
   logic [N_BTN-1:0] o_btn_level;
   logic [N_BTN-1:0] o_btn_pulse;
   logic [N_BTN-1:0] o_btn_release;

   int n_cmp;
   int n_err;

   btn_debounce_pulse #(
      .N_BTN           (N_BTN),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_btn_raw     (i_btn_raw),
      .o_btn_level   (o_btn_level),
      .o_btn_pulse   (o_btn_pulse),
      .o_btn_release (o_btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {o_btn_level, o_btn_pulse, o_btn_release};
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b (level,pulse,release)", tag, obs, exp);
      end
   endtask

   // Step n edges, checking the same expected vector after each.
   task automatic steps_chk(input string tag, input int n, input logic [5:0] exp);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, exp);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b1;
      i_btn_raw = 2'b11;

      // Reset held 3 cycles with both buttons pressed: all outputs 0.
      steps_chk("reset", 3, 6'b00_00_00);
      reset = 1'b0;
      // Buttons held through reset are re-debounced: accepted after edge 6.
      steps_chk("post_reset_wait", 5, 6'b00_00_00);
      steps_chk("post_reset_pulse", 1, 6'b11_11_00);
      steps_chk("post_reset_held", 1, 6'b11_00_00);

      // Release both together.
      i_btn_raw = 2'b00;
      steps_chk("rel_both_wait", 5, 6'b11_00_00);
      steps_chk("rel_both_pulse", 1, 6'b00_00_11);
      steps_chk("rel_both_idle", 2, 6'b00_00_00);

      // Clean press on channel 0, held.
      i_btn_raw = 2'b01;
      steps_chk("press0_wait", 5, 6'b00_00_00);
      steps_chk("press0_pulse", 1, 6'b01_01_00);
      for (int k = 1; k <= 24; k++) begin
         step();
         if (c_rep_en && (k == 10 || (k >= 13 && (k - 10) % 3 == 0)))
            chk("press0_hold_repeat", 6'b01_01_00);
         else
            chk("press0_hold", 6'b01_00_00);
      end

      // Release channel 0.
      i_btn_raw = 2'b00;
      steps_chk("rel0_wait", 5, 6'b01_00_00);
      steps_chk("rel0_pulse", 1, 6'b00_00_01);
      steps_chk("rel0_idle", 2, 6'b00_00_00);

      // Glitch: 3 edges high is one short of acceptance.
      i_btn_raw = 2'b01;
      step(); step(); step();
      chk("glitch_early", 6'b00_00_00);
      i_btn_raw = 2'b00;
      steps_chk("glitch", 10, 6'b00_00_00);

      // Boundary: exactly 4 edges high is accepted, then released.
      i_btn_raw = 2'b01;
      steps_chk("min_press_wait", 4, 6'b00_00_00);
      i_btn_raw = 2'b00;
      steps_chk("min_press_wait2", 1, 6'b00_00_00);
      steps_chk("min_press_pulse", 1, 6'b01_01_00);
      steps_chk("min_press_held", 3, 6'b01_00_00);
      steps_chk("min_press_rel", 1, 6'b00_00_01);
      steps_chk("min_press_idle", 2, 6'b00_00_00);

      // Press bounce 1,0,1,1,...: counting restarts, single pulse after edge 8.
      i_btn_raw = 2'b01;
      step();
      chk("bounce_e1", 6'b00_00_00);
      i_btn_raw = 2'b00;
      step();
      chk("bounce_e2", 6'b00_00_00);
      i_btn_raw = 2'b01;
      steps_chk("bounce_wait", 5, 6'b00_00_00);
      steps_chk("bounce_pulse", 1, 6'b01_01_00);
      steps_chk("bounce_held", 3, 6'b01_00_00);

      // Press channel 1 while channel 0 stays held: independent channels.
      i_btn_raw = 2'b11;
      steps_chk("press1_wait", 5, 6'b01_00_00);
      steps_chk("press1_pulse", 1, 6'b11_10_00);
      steps_chk("press1_held", 2, 6'b11_00_00);

      // Release channel 1 with a bounce 0,1,0,0,...: release after edge 8.
      i_btn_raw = 2'b01;
      step();
      chk("rel1_e1", 6'b11_00_00);
      i_btn_raw = 2'b11;
      step();
      chk("rel1_e2", 6'b11_00_00);
      i_btn_raw = 2'b01;
      steps_chk("rel1_wait", 5, 6'b11_00_00);
      steps_chk("rel1_pulse", 1, 6'b01_00_10);
      steps_chk("rel1_idle", 2, 6'b01_00_00);

      // Reset while channel 0 is held: cleared, then a fresh pulse.
      reset = 1'b1;
      steps_chk("midreset", 1, 6'b00_00_00);
      reset = 1'b0;
      steps_chk("midreset_wait", 5, 6'b00_00_00);
      steps_chk("midreset_pulse", 1, 6'b01_01_00);
      steps_chk("midreset_held", 2, 6'b01_00_00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_btn_debounce_pulse
`default_nettype wire
